// File: rtl/round_key_sequencer.sv
// ---------------------------------------------------------------------------
// round_key_sequencer
//
// Derives NUM_ROUNDS round keys from one master key using an external
// key_reduction block. The master key is taken over a valid/ready port and
// placed on red_src. Each reduced result is sampled from red_res and offered
// to the cipher core over a valid/ready port. The working key is then rotated
// left by ROT bits and reduced again for the next round.
//
// Ports
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   key_valid  in   1          master key offered
//   key_ready  out  1          master key can be accepted (IDLE only)
//   key_in     in   KEY_W      master key
//   abort      in   1          synchronous abort of the current schedule
//   red_src    out  KEY_W      working key, drives key_reduction.key
//   red_res    in   RK_W       key_reduction.red_key
//   rk_valid   out  1          round key valid
//   rk_ready   in   1          consumer accepts round key
//   rk_data    out  RK_W       round key
//   rk_idx     out  IDX_W      round index of rk_data
//   rk_last    out  1          final round key of the schedule is on rk_data
//   busy       out  1          a schedule is in progress
// ---------------------------------------------------------------------------
module round_key_sequencer #(
    parameter int KEY_W      = 512,
    parameter int RK_W       = 16,
    parameter int NUM_ROUNDS = 8,
    parameter int RED_LAT    = 1,
    parameter int ROT        = 61,
    // Derived from NUM_ROUNDS; leave at its default.
    parameter int IDX_W      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    input  logic             abort,
    output logic [KEY_W-1:0] red_src,
    input  logic [RK_W-1:0]  red_res,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_data,
    output logic [IDX_W-1:0] rk_idx,
    output logic             rk_last,
    output logic             busy
);

    localparam int CNT_W = (RED_LAT > 0) ? $clog2(RED_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic [KEY_W-1:0]   r_src;
    logic [RK_W-1:0]    r_data;
    logic [IDX_W-1:0]   r_idx;

    logic               w_isLast;
    logic               w_handshake;
    logic [KEY_W-1:0]   w_rotated;

    assign w_isLast    = (r_idx == IDX_W'(NUM_ROUNDS - 1));
    assign w_handshake = (r_state == S_EMIT) && rk_ready;

    // Shift-based rotate so that ROT = 0 stays legal (the right shift by
    // KEY_W then contributes nothing and the key passes through unchanged).
    assign w_rotated = (r_src << ROT) | (r_src >> (KEY_W - ROT));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; abort overrides every other transition, including a
    // key accept in IDLE and a round-key handshake in EMIT.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (key_valid)      w_nextState = S_WAIT;
            S_WAIT: if (r_cnt == '0)    w_nextState = S_EMIT;
            S_EMIT: if (rk_ready)       w_nextState = w_isLast ? S_IDLE : S_WAIT;
            default:                    w_nextState = S_IDLE;
        endcase
        if (abort) begin
            w_nextState = S_IDLE;
        end
    end

    // Datapath registers. The latency counter is loaded with RED_LAT whenever
    // red_src changes, so the result is sampled once key_reduction has settled.
    // Abort leaves red_src and rk_data untouched; only the schedule position
    // is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_src  <= '0;
            r_data <= '0;
            r_idx  <= '0;
        end else if (abort) begin
            r_cnt  <= '0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (key_valid) begin
                        r_src <= key_in;
                        r_idx <= '0;
                        r_cnt <= CNT_W'(RED_LAT);
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_data <= red_res;
                    end
                end
                S_EMIT: begin
                    if (w_handshake && !w_isLast) begin
                        r_idx <= r_idx + IDX_W'(1);
                        r_src <= w_rotated;
                        r_cnt <= CNT_W'(RED_LAT);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign key_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rk_valid  = (r_state == S_EMIT);
    assign rk_last   = rk_valid && w_isLast;
    assign red_src   = r_src;
    assign rk_data   = r_data;
    assign rk_idx    = r_idx;

endmodule

// File: tb/tb_round_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_round_key_sequencer
//
// Directed testbench for round_key_sequencer. A one-cycle key_reduction model
// (XOR of all 16-bit slices of the key) feeds red_res; expected round keys
// come from an independent rotate-and-reduce golden model.
// ---------------------------------------------------------------------------
module tb_round_key_sequencer;

    localparam int KEY_W      = 512;
    localparam int RK_W       = 16;
    localparam int NUM_ROUNDS = 8;
    localparam int RED_LAT    = 1;
    localparam int ROT        = 61;
    localparam int IDX_W      = 3;

    logic             clk;
    logic             rst_n;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_in;
    logic             abort;
    logic [KEY_W-1:0] red_src;
    logic [RK_W-1:0]  red_res;
    logic             rk_valid;
    logic             rk_ready;
    logic [RK_W-1:0]  rk_data;
    logic [IDX_W-1:0] rk_idx;
    logic             rk_last;
    logic             busy;

    int checkCount = 0;
    int errorCount = 0;

    round_key_sequencer #(
        .KEY_W(KEY_W), .RK_W(RK_W), .NUM_ROUNDS(NUM_ROUNDS),
        .RED_LAT(RED_LAT), .ROT(ROT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .abort(abort), .red_src(red_src), .red_res(red_res),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_idx(rk_idx), .rk_last(rk_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden reduction: XOR of the 32 sixteen-bit slices of the key.
    function automatic logic [RK_W-1:0] reduceKey(input logic [KEY_W-1:0] k);
        logic [RK_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEY_W / RK_W; i++) r = r ^ k[i*RK_W +: RK_W];
        return r;
    endfunction

    function automatic logic [KEY_W-1:0] rotl(input logic [KEY_W-1:0] k);
        return {k[KEY_W-1-ROT:0], k[KEY_W-1:KEY_W-ROT]};
    endfunction

    function automatic logic [KEY_W-1:0] makeKey();
        logic [KEY_W-1:0] k;
        for (int w = 0; w < KEY_W / 32; w++) k[w*32 +: 32] = $urandom;
        return k;
    endfunction

    // key_reduction model with RED_LAT = 1.
    initial red_res = '0;
    always @(posedge clk) red_res <= reduceKey(red_src);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer a master key and confirm it was taken.
    task automatic applyStimulus(input logic [KEY_W-1:0] k);
        int waited;
        waited = 0;
        while (!key_ready && waited < 40) begin
            tick();
            waited++;
        end
        key_valid = 1'b1;
        key_in    = k;
        tick();
        key_valid = 1'b0;
        checkOutput("busy after accept", 64'(busy), 64'd1);
    endtask

    // Consume numRounds round keys of the schedule started from key.
    task automatic collectKeys(input logic [KEY_W-1:0] key, input int numRounds,
                               input bit holdReady, input bit checkSpacing,
                               input int stallIdx, input int stallLen,
                               input bit randStall, input bit pokeKey);
        logic [KEY_W-1:0] k;
        logic [RK_W-1:0]  expData;
        int waited;
        int sinceLast;
        int n;
        k = key;
        sinceLast = 0;
        for (int i = 0; i < numRounds; i++) begin
            expData = reduceKey(k);
            waited = 0;
            if (pokeKey) begin
                key_valid = 1'b1;
                key_in    = ~key;
            end
            while (!rk_valid && waited < 40) begin
                if (pokeKey) checkOutput("key_ready while busy", 64'(key_ready), 64'd0);
                tick();
                waited++;
            end
            key_valid = 1'b0;
            if (!rk_valid) begin
                checkOutput("rk_valid timeout", 64'd0, 64'd1);
                return;
            end
            if (checkSpacing)
                checkOutput("rk spacing", 64'(sinceLast + waited), (i == 0) ? 64'd2 : 64'd3);
            n = 0;
            if (!holdReady) begin
                if (i == stallIdx)  n = stallLen;
                else if (randStall) n = $urandom_range(0, 2);
            end
            for (int j = 0; j < n; j++) begin
                rk_ready = 1'b0;
                tick();
                checkOutput("stall rk_valid", 64'(rk_valid), 64'd1);
                checkOutput("stall rk_data", 64'(rk_data), 64'(expData));
                checkOutput("stall rk_idx", 64'(rk_idx), 64'(i));
            end
            checkOutput("rk_data", 64'(rk_data), 64'(expData));
            checkOutput("rk_idx", 64'(rk_idx), 64'(i));
            checkOutput("rk_last", 64'(rk_last), 64'(i == NUM_ROUNDS - 1));
            rk_ready = 1'b1;
            tick();
            if (!holdReady) rk_ready = 1'b0;
            sinceLast = 1;
            k = rotl(k);
        end
    endtask

    task automatic waitValid(input string tag);
        int waited;
        waited = 0;
        while (!rk_valid && waited < 40) begin
            tick();
            waited++;
        end
        checkOutput(tag, 64'(rk_valid), 64'd1);
    endtask

    initial begin
        logic [KEY_W-1:0] keyA;
        logic [KEY_W-1:0] keyB;
        int validSeen;

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        abort     = 1'b0;
        rk_ready  = 1'b0;

        // Test 1: reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'($urandom);
            abort     = 1'($urandom);
            rk_ready  = 1'($urandom);
            key_in    = makeKey();
            tick();
        end
        checkOutput("reset rk_valid", 64'(rk_valid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset key_ready", 64'(key_ready), 64'd1);
        checkOutput("reset rk_data", 64'(rk_data), 64'd0);
        checkOutput("reset rk_last", 64'(rk_last), 64'd0);
        key_valid = 1'b0;
        abort     = 1'b0;
        rk_ready  = 1'b0;
        rst_n     = 1'b1;
        tick();

        // Test 2: zero key, rk_ready held high, spacing checked.
        rk_ready = 1'b1;
        applyStimulus('0);
        collectKeys('0, NUM_ROUNDS, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0);
        rk_ready = 1'b0;
        checkOutput("busy after schedule", 64'(busy), 64'd0);
        checkOutput("key_ready after schedule", 64'(key_ready), 64'd1);

        // Test 3: random key with backpressure, 5-cycle stall on round 3.
        keyA = makeKey();
        applyStimulus(keyA);
        collectKeys(keyA, NUM_ROUNDS, 1'b0, 1'b0, 3, 5, 1'b1, 1'b0);
        checkOutput("busy after stalled schedule", 64'(busy), 64'd0);

        // Test 4: key_valid pulsed while busy must not disturb the schedule.
        keyA = makeKey();
        applyStimulus(keyA);
        collectKeys(keyA, NUM_ROUNDS, 1'b0, 1'b1, -1, 0, 1'b0, 1'b1);
        checkOutput("busy after poked schedule", 64'(busy), 64'd0);

        // Test 5a: abort during WAIT of round 2.
        keyA = makeKey();
        applyStimulus(keyA);
        collectKeys(keyA, 2, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort wait busy", 64'(busy), 64'd0);
        checkOutput("abort wait rk_valid", 64'(rk_valid), 64'd0);
        checkOutput("abort wait rk_idx", 64'(rk_idx), 64'd0);
        validSeen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rk_valid) validSeen++;
        end
        checkOutput("no keys after abort", 64'(validSeen), 64'd0);

        // Test 5b: abort together with key_valid in IDLE does not accept.
        key_valid = 1'b1;
        key_in    = makeKey();
        abort     = 1'b1;
        tick();
        key_valid = 1'b0;
        abort     = 1'b0;
        checkOutput("abort blocks accept", 64'(busy), 64'd0);

        // Test 5c: abort on the same cycle as a round-key handshake.
        keyA = makeKey();
        applyStimulus(keyA);
        collectKeys(keyA, 3, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);
        waitValid("round 3 valid");
        rk_ready = 1'b1;
        abort    = 1'b1;
        tick();
        rk_ready = 1'b0;
        abort    = 1'b0;
        checkOutput("abort hs busy", 64'(busy), 64'd0);
        checkOutput("abort hs rk_valid", 64'(rk_valid), 64'd0);
        checkOutput("abort hs rk_idx", 64'(rk_idx), 64'd0);
        keyB = makeKey();
        applyStimulus(keyB);
        collectKeys(keyB, NUM_ROUNDS, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0);

        // Test 6: asynchronous reset while in EMIT of round 5.
        keyA = makeKey();
        applyStimulus(keyA);
        collectKeys(keyA, 5, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);
        waitValid("round 5 valid");
        checkOutput("round 5 idx", 64'(rk_idx), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset rk_valid", 64'(rk_valid), 64'd0);
        checkOutput("async reset busy", 64'(busy), 64'd0);
        checkOutput("async reset key_ready", 64'(key_ready), 64'd1);
        checkOutput("async reset rk_data", 64'(rk_data), 64'd0);
        checkOutput("async reset rk_idx", 64'(rk_idx), 64'd0);
        checkOutput("async reset red_src", 64'(red_src), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        keyB = makeKey();
        applyStimulus(keyB);
        collectKeys(keyB, NUM_ROUNDS, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0);
        checkOutput("busy after post-reset schedule", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
